// File: rtl/audio_rate_gen.sv
// Fractional-N audio sample strobe generator: a Bresenham accumulator adds the
// sample rate each cycle and wraps at freq*1e6, so the long-term rate is exact.
module audio_rate_gen #(
  parameter int unsigned RATE0     = 32000,
  parameter int unsigned RATE1     = 44100,
  parameter int unsigned RATE2     = 48000,
  parameter int unsigned RATE3     = 96000,
  parameter int unsigned BLOCK_LEN = 192,
  parameter int unsigned ACC_W     = 28,
  parameter int unsigned IDX_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [7:0]       freq,
  input  logic [1:0]       rate_sel,
  output logic             audio_stb,
  output logic             block_stb,
  output logic [IDX_W-1:0] sample_idx,
  output logic             active
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [ACC_W-1:0] MHZ      = ACC_W'(1000000);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_LEN - 1);

  state_t           state;
  logic [7:0]       freq_q;
  logic [1:0]       sel_q;
  logic [ACC_W-1:0] acc, modulus, step;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] rate_lut;
  logic [ACC_W:0]   sum;
  logic             stop, cfg_chg;

  always_comb begin
    rate_lut = ACC_W'(RATE0);
    case (rate_sel)
      2'd1:    rate_lut = ACC_W'(RATE1);
      2'd2:    rate_lut = ACC_W'(RATE2);
      2'd3:    rate_lut = ACC_W'(RATE3);
      default: rate_lut = ACC_W'(RATE0);
    endcase
  end

  // One extra bit so acc+step never wraps before the compare.
  assign sum     = {1'b0, acc} + {1'b0, step};
  assign stop    = !en || (freq == 8'd0);
  assign cfg_chg = (freq != freq_q) || (rate_sel != sel_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      freq_q     <= '0;
      sel_q      <= '0;
      acc        <= '0;
      modulus    <= '0;
      step       <= '0;
      idx        <= '0;
      audio_stb  <= 1'b0;
      block_stb  <= 1'b0;
      sample_idx <= '0;
      active     <= 1'b0;
    end else begin
      audio_stb <= 1'b0;
      block_stb <= 1'b0;
      case (state)
        IDLE: begin
          active <= 1'b0;
          if (!stop) state <= LOAD;
        end
        LOAD: begin
          freq_q  <= freq;
          sel_q   <= rate_sel;
          modulus <= ACC_W'(freq) * MHZ;
          step    <= rate_lut;
          acc     <= '0;
          idx     <= '0;
          state   <= RUN;
          active  <= 1'b1;
        end
        RUN: begin
          // Disable beats reconfiguration; both abandon the current phase.
          if (stop) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (cfg_chg) begin
            state  <= LOAD;
            active <= 1'b0;
          end else if (sum >= {1'b0, modulus}) begin
            acc        <= ACC_W'(sum - {1'b0, modulus});
            audio_stb  <= 1'b1;
            sample_idx <= idx;
            block_stb  <= (idx == '0);
            idx        <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          end else begin
            acc <= sum[ACC_W-1:0];
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_rate_gen.sv
// Scoreboard bench: expected strobe edges come from the closed form
// ceil(k*modulus/step) and are popped as the DUT strobes.
module tb_audio_rate_gen;
  localparam int BLOCK_LEN = 192;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] freq = '0;
  logic [1:0] rate_sel = '0;
  logic       audio_stb, block_stb, active;
  logic [7:0] sample_idx;

  typedef struct {int at; int idx; bit blk;} exp_t;
  exp_t sb[$];
  int vecs = 0;
  int errs = 0;

  audio_rate_gen dut (
    .clk(clk), .reset_n(reset_n), .en(en), .freq(freq), .rate_sel(rate_sel),
    .audio_stb(audio_stb), .block_stb(block_stb), .sample_idx(sample_idx),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two edges: leaving IDLE/RUN into LOAD, then LOAD into RUN.
  task automatic expect_load(input string tag);
    tick();
    vecs++;
    if (active !== 1'b0 || audio_stb !== 1'b0) begin
      errs++;
      $display("FAIL %s load_cycle: active=%0b stb=%0b want 0/0", tag, active, audio_stb);
    end
    tick();
    vecs++;
    if (active !== 1'b1) begin
      errs++;
      $display("FAIL %s run_entry: active=%0b want 1", tag, active);
    end
  endtask

  // Runs n RUN edges from a fresh LOAD; every strobe must match the scoreboard.
  task automatic run_window(input string tag, input int n, input longint m, input longint s);
    exp_t e;
    int expected_cnt = 0;
    int seen = 0;
    sb.delete();
    for (longint k = 1; ; k++) begin
      longint at = (k * m + s - 1) / s;
      if (at > n) break;
      e.at = int'(at);
      e.idx = int'((k - 1) % BLOCK_LEN);
      e.blk = ((k - 1) % BLOCK_LEN) == 0;
      sb.push_back(e);
      expected_cnt++;
    end
    for (int c = 1; c <= n; c++) begin
      tick();
      if (audio_stb === 1'b1) begin
        seen++;
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL %s extra_strobe: at edge %0d, none expected", tag, c);
        end else begin
          e = sb.pop_front();
          if (c != e.at) begin
            errs++;
            $display("FAIL %s strobe_edge: got edge %0d want %0d", tag, c, e.at);
          end
          vecs++;
          if (int'(sample_idx) != e.idx) begin
            errs++;
            $display("FAIL %s sample_idx: got %0d want %0d", tag, sample_idx, e.idx);
          end
          vecs++;
          if (block_stb !== e.blk) begin
            errs++;
            $display("FAIL %s block_stb: got %0b want %0b at idx %0d", tag, block_stb, e.blk, e.idx);
          end
        end
      end else if (block_stb !== 1'b0 || active !== 1'b1) begin
        errs++;
        $display("FAIL %s idle_cycle: block_stb=%0b active=%0b at edge %0d", tag, block_stb, active, c);
      end
    end
    vecs++;
    if (seen != expected_cnt) begin
      errs++;
      $display("FAIL %s strobe_count: got %0d want %0d", tag, seen, expected_cnt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    vecs += 4;
    if (audio_stb !== 1'b0) begin errs++; $display("FAIL reset audio_stb: got %0b want 0", audio_stb); end
    if (block_stb !== 1'b0) begin errs++; $display("FAIL reset block_stb: got %0b want 0", block_stb); end
    if (sample_idx !== 8'd0) begin errs++; $display("FAIL reset sample_idx: got %0d want 0", sample_idx); end
    if (active !== 1'b0) begin errs++; $display("FAIL reset active: got %0b want 0", active); end
  endtask

  task automatic test_rate48();
    en = 1'b1; freq = 8'd1; rate_sel = 2'd2;
    #2 reset_n = 1'b1;
    expect_load("rate48");
    run_window("rate48", 2000, 1000000, 48000);
  endtask

  task automatic test_rate_change();
    rate_sel = 2'd3;
    expect_load("rate_change");
    run_window("rate_change", 300, 1000000, 96000);
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (active !== 1'b0 || audio_stb !== 1'b0) begin
        errs++;
        $display("FAIL en_drop idle: active=%0b stb=%0b want 0/0", active, audio_stb);
      end
    end
    en = 1'b1;
    expect_load("en_drop");
    run_window("en_drop", 200, 1000000, 96000);
  endtask

  task automatic test_rate441();
    rate_sel = 2'd1;
    expect_load("rate441");
    run_window("rate441", 10000, 1000000, 44100);
  endtask

  task automatic test_freq0();
    freq = 8'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (active !== 1'b0 || audio_stb !== 1'b0) begin
        errs++;
        $display("FAIL freq0 idle: active=%0b stb=%0b want 0/0", active, audio_stb);
      end
    end
    freq = 8'd28; rate_sel = 2'd2;
    expect_load("freq28");
    run_window("freq28", 28000, 64'd28000000, 48000);
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      hit = (audio_stb === 1'b1);
    end
    vecs++;
    if (!hit) begin
      errs++;
      $display("FAIL reset_mid wait_strobe: got none in 2000 edges want 1");
    end else begin
      #2 reset_n = 1'b0;
      #1;
      vecs++;
      if (audio_stb !== 1'b0 || block_stb !== 1'b0 || active !== 1'b0) begin
        errs++;
        $display("FAIL reset_mid async_clear: stb=%0b blk=%0b act=%0b want 0/0/0",
                 audio_stb, block_stb, active);
      end
      #2 reset_n = 1'b1;
      expect_load("reset_mid");
      run_window("reset_mid", 1200, 64'd28000000, 48000);
    end
  endtask

  initial begin
    test_reset();
    test_rate48();
    test_rate_change();
    test_en_drop();
    test_rate441();
    test_freq0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
